// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-driven enable/flush/forward sequencer for the 5-stage core; controls are combinational, state moves on cpu_clk.
// A Bridge wait in MEM freezes every stage for up to BUS_TIMEOUT cycles. Define FORWARD_EN for EX bypassing; otherwise every RAW stalls until the producer leaves WB.
module hazard_ctrl #(
   parameter int BUS_TIMEOUT = 15,
   parameter int TO_W        = 4
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst,
   input  logic        id_valid,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_rs1_used,
   input  logic        id_rs2_used,
   input  logic [4:0]  id_rd,
   input  logic        id_rf_we,
   input  logic        id_is_load,
   input  logic        ex_redirect,
   input  logic        mem_bus_req,
   input  logic        bus_ready,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        if_id_flush,
   output logic        id_ex_en,
   output logic        id_ex_flush,
   output logic        ex_mem_en,
   output logic        mem_wb_en,
   output logic [1:0]  fwd_a_sel,
   output logic [1:0]  fwd_b_sel,
   output logic        bus_err,
   output logic [31:0] stall_cycles
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       we;
      logic       is_load;
   } dst_t;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rs1_used;
      logic       rs2_used;
   } src_t;

   typedef enum logic {RUN, BUS_WAIT} state_t;

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(BUS_TIMEOUT);

   state_t          state, state_nxt;
   logic [TO_W-1:0] wait_cnt, wait_cnt_nxt;
   dst_t            ex_dst, mem_dst, wb_dst;
   src_t            ex_src;
   logic            mem_pending;
   logic            frozen;
   logic            timeout_rel;
   logic            raw_stall;

   // x0 is never a real dependency, so rs==0 can never match
   function automatic logic writes(input dst_t d, input logic [4:0] rs, input logic used);
      return used && (rs != 5'd0) && d.valid && d.we && (d.rd == rs);
   endfunction

   always_comb begin
      raw_stall = 1'b0;
      if (id_valid) begin
`ifdef FORWARD_EN
         raw_stall = ex_dst.is_load &&
                     (writes(ex_dst, id_rs1, id_rs1_used) || writes(ex_dst, id_rs2, id_rs2_used));
`else
         raw_stall = writes(ex_dst,  id_rs1, id_rs1_used) || writes(ex_dst,  id_rs2, id_rs2_used) ||
                     writes(mem_dst, id_rs1, id_rs1_used) || writes(mem_dst, id_rs2, id_rs2_used) ||
                     writes(wb_dst,  id_rs1, id_rs1_used) || writes(wb_dst,  id_rs2, id_rs2_used);
`endif
      end
   end

   always_comb begin
      state_nxt   = state;
      frozen      = 1'b0;
      timeout_rel = 1'b0;
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b0;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      mem_pending = mem_dst.valid && mem_bus_req && !bus_ready;

      case (state)
         RUN: begin
            if (mem_pending) begin
               frozen    = 1'b1;
               state_nxt = BUS_WAIT;
            end
         end
         BUS_WAIT: begin
            if (bus_ready) begin
               state_nxt = RUN;
            end else if (wait_cnt == TO_LIMIT) begin
               timeout_rel = 1'b1;
               state_nxt   = RUN;
            end else begin
               frozen = 1'b1;
            end
         end
         default: state_nxt = RUN;
      endcase

      wait_cnt_nxt = frozen ? wait_cnt + 1'b1 : '0;

      // freeze overrides everything; a wrong-path ID makes its data stall moot
      if (frozen) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
      end else if (ex_redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (raw_stall) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

`ifdef FORWARD_EN
   function automatic logic [1:0] fwd_pick(input dst_t m, input dst_t w,
                                           input logic [4:0] rs, input logic used);
      if (writes(m, rs, used) && !m.is_load) return 2'b01;
      if (writes(w, rs, used))               return 2'b10;
      return 2'b00;
   endfunction

   always_comb begin
      fwd_a_sel = fwd_pick(mem_dst, wb_dst, ex_src.rs1, ex_dst.valid && ex_src.rs1_used);
      fwd_b_sel = fwd_pick(mem_dst, wb_dst, ex_src.rs2, ex_dst.valid && ex_src.rs2_used);
   end

   logic unused_fwd_fields;
   assign unused_fwd_fields = wb_dst.is_load;
`else
   assign fwd_a_sel = 2'b00;
   assign fwd_b_sel = 2'b00;

   // source tracking and load flags only feed the bypass network
   logic unused_fwd_fields;
   assign unused_fwd_fields = ^{ex_src, ex_dst.is_load, mem_dst.is_load, wb_dst.is_load};
`endif

   always_ff @(posedge cpu_clk) begin
      if (!cpu_rst) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (!cpu_rst) begin
         ex_dst       <= '0;
         ex_src       <= '0;
         mem_dst      <= '0;
         wb_dst       <= '0;
         bus_err      <= 1'b0;
         stall_cycles <= '0;
      end else begin
         if (timeout_rel) bus_err <= 1'b1;
         if (!pc_en) stall_cycles <= stall_cycles + 32'd1;
         if (mem_wb_en) wb_dst <= mem_dst;
         if (ex_mem_en) mem_dst <= ex_dst;
         if (id_ex_en) begin
            if (id_ex_flush) begin
               ex_dst <= '0;
               ex_src <= '0;
            end else begin
               ex_dst.valid     <= id_valid;
               ex_dst.rd        <= id_rd;
               ex_dst.we        <= id_rf_we;
               ex_dst.is_load   <= id_is_load;
               ex_src.rs1       <= id_rs1;
               ex_src.rs2       <= id_rs2;
               ex_src.rs1_used  <= id_rs1_used;
               ex_src.rs2_used  <= id_rs2_used;
            end
         end
      end
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage IF/ID/EX/MEM/WB core.
- Tracks in-flight destination registers per stage in an internal scoreboard and drives the enable/flush inputs of PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Drives the EX operand forwarding selects.
- Freezes the pipeline while a Bridge access in MEM is not ready, bounded by a timeout.

Parameters:
BUS_TIMEOUT, 15, max consecutive bus wait cycles before forced release (1..2^TO_W-1)
TO_W, 4, width of bus wait counter

Ports:
cpu_clk  input  1  clock, all state updates on rising edge
cpu_rst  input  1  reset, synchronous, active-low
id_valid  input  1  ID holds a real instruction
id_rs1  input  5  ID source reg 1
id_rs2  input  5  ID source reg 2
id_rs1_used  input  1  ID reads rs1
id_rs2_used  input  1  ID reads rs2
id_rd  input  5  ID destination reg
id_rf_we  input  1  ID writes rf
id_is_load  input  1  ID rf_wsel selects DRAM read data
ex_redirect  input  1  EX resolves taken branch/jump (npc != pc4)
mem_bus_req  input  1  MEM stage accesses Bridge (load or store)
bus_ready  input  1  Bridge completes access this cycle
pc_en  output  1  PC update enable
if_id_en  output  1  IF_ID load enable
if_id_flush  output  1  IF_ID load bubble
id_ex_en  output  1  ID_EX load enable
id_ex_flush  output  1  ID_EX load bubble
ex_mem_en  output  1  EX_MEM load enable
mem_wb_en  output  1  MEM_WB load enable
fwd_a_sel  output  2  EX operand A: 00 rD1, 01 EX_MEM alu result, 10 WB wD
fwd_b_sel  output  2  EX operand B (rD2 path), same encoding
bus_err  output  1  sticky: a bus timeout occurred
stall_cycles  output  32  count of cycles with pc_en=0

Behaviour:
- Scoreboard: per stage EX/MEM/WB holds {valid, rd, we, is_load}. EX stage additionally holds {rs1, rs2, rs1_used, rs2_used}.
- Stages advance with their enable. A flushed stage loads valid=0.
- Register x0 never matches: rd=0 or rs=0 is treated as no hazard.
- Reset (cpu_rst=0 at edge): all valid bits 0, FSM=RUN, wait counter 0, bus_err=0, stall_cycles=0.
- Outputs after reset: all *_en=1, all *_flush=0, fwd_*=00.
- Enables and flushes are combinational from FSM, scoreboard and inputs. All effects take place at the next clock edge.
- FSM states RUN, BUS_WAIT.
  - RUN to BUS_WAIT: MEM valid, mem_bus_req=1, bus_ready=0.
  - BUS_WAIT to RUN: bus_ready=1, or the counter reaches BUS_TIMEOUT.
  - On timeout, set bus_err=1 and release exactly as if bus_ready had been seen.
- Freeze condition: (RUN and request not ready) or (BUS_WAIT and not release).
  - While frozen, all *_en=0 and all flushes=0, regardless of other conditions.
  - The counter increments every frozen cycle and clears on leaving BUS_WAIT.
- Redirect (not frozen, ex_redirect=1): if_id_flush=1, id_ex_flush=1, all enables 1.
  - Redirect beats the data stall, because the ID instruction is wrong-path.
  - A redirect raised while frozen is held in EX and takes effect on the first unfrozen cycle.
- Load-use stall (not frozen, no redirect):
  - Condition: id_valid, EX valid/we/is_load, and EX rd equals a used ID rs.
  - Response: pc_en=0, if_id_en=0, id_ex_flush=1. EX_MEM and MEM_WB advance.
  - Stall lasts exactly 1 cycle.
- Forwarding, per EX operand:
  - 01 if MEM valid & we & !is_load & MEM rd == EX rs.
  - Else 10 if WB valid & we & WB rd == EX rs.
  - Else 00. MEM beats WB.
  - Outputs 00 when the operand is unused.
- stall_cycles wraps from 0xFFFFFFFF to 0. It increments on any cycle where pc_en=0, freeze included.
- Simultaneous load-use with a request not ready: freeze wins. The load-use stall is re-evaluated after release.

Optional Feature:
FORWARD_EN
- Defined: forwarding as above; only load-use stalls.
- Undefined: fwd_*_sel tied to 00.
  - The register file does not bypass, so any RAW against a valid/we EX, MEM or WB entry stalls.
  - Stall response is the same as load-use (pc_en=0, if_id_en=0, id_ex_flush=1) until the producer has left WB.
  - Back-to-back dependency costs 3 stall cycles.

Test Plan:
- Reset: hold cpu_rst=0 for 2 cycles, release -> all *_en=1, flushes 0, fwd 00, bus_err=0, stall_cycles=0.
- lw x5; add x6,x5,x1 -> one cycle pc_en=0/if_id_en=0/id_ex_flush=1, then fwd_a_sel=10 for add in EX. stall_cycles=1.
- (FORWARD_EN) add x3; sub x4,x3,x3 -> no stall, fwd_a_sel=fwd_b_sel=01. Same with writes to x0 -> fwd 00.
- Store in MEM, bus_ready low 3 cycles then high -> exactly 3 frozen cycles with all *_en=0, then RUN, bus_err=0.
- bus_ready held low -> freeze lasts BUS_TIMEOUT=15 cycles, bus_err=1 and stays 1, pipeline resumes.
- ex_redirect=1 coinciding with a load-use match in ID -> if_id_flush=id_ex_flush=1, pc_en=1, no stall cycle counted.
